// File: rtl/conv2_window_buf.sv
// Three-channel line buffer producing FILTER_SIZE x FILTER_SIZE conv2 windows; window and valid_out
// appear 1 clk after the accepted bottom-right pixel; no backpressure, every valid_out must be consumed.
module conv2_window_buf #(
  parameter int CONV_BIT    = 12,
  parameter int WIDTH       = 12,
  parameter int HEIGHT      = 12,
  parameter int WIDTH_BIT   = 4,
  parameter int FILTER_SIZE = 5
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         valid_in,
  input  logic [CONV_BIT-1:0]                          pool_in_1,
  input  logic [CONV_BIT-1:0]                          pool_in_2,
  input  logic [CONV_BIT-1:0]                          pool_in_3,
  output logic [FILTER_SIZE*FILTER_SIZE*CONV_BIT-1:0]  window_1,
  output logic [FILTER_SIZE*FILTER_SIZE*CONV_BIT-1:0]  window_2,
  output logic [FILTER_SIZE*FILTER_SIZE*CONV_BIT-1:0]  window_3,
  output logic                                         valid_out,
  output logic                                         frame_done
);

  localparam int F = FILTER_SIZE;
  localparam int L = (F - 1) * WIDTH + F;
  localparam logic [WIDTH_BIT-1:0] COL_LAST = WIDTH_BIT'(WIDTH - 1);
  localparam logic [WIDTH_BIT-1:0] ROW_LAST = WIDTH_BIT'(HEIGHT - 1);
  localparam logic [WIDTH_BIT-1:0] EDGE     = WIDTH_BIT'(F - 1);

  logic [CONV_BIT-1:0]  sr1_q [L];
  logic [CONV_BIT-1:0]  sr2_q [L];
  logic [CONV_BIT-1:0]  sr3_q [L];
  logic [WIDTH_BIT-1:0] col_q, col_d;
  logic [WIDTH_BIT-1:0] row_q, row_d;
  logic                 valid_out_q, valid_out_d;
  logic                 frame_done_q, frame_done_d;

  // Flags are judged on the pre-increment position of the pixel being accepted.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    valid_out_d  = 1'b0;
    frame_done_d = 1'b0;
    if (valid_in) begin
      valid_out_d  = (row_q >= EDGE) && (col_q >= EDGE);
      frame_done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < L; i++) begin
        sr1_q[i] <= '0;
        sr2_q[i] <= '0;
        sr3_q[i] <= '0;
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
      if (valid_in) begin
        sr1_q[0] <= pool_in_1;
        sr2_q[0] <= pool_in_2;
        sr3_q[0] <= pool_in_3;
        for (int i = 1; i < L; i++) begin
          sr1_q[i] <= sr1_q[i-1];
          sr2_q[i] <= sr2_q[i-1];
          sr3_q[i] <= sr3_q[i-1];
        end
      end
    end
  end

  // Row r = 0 is the oldest line; taps are one WIDTH apart per row.
  for (genvar r = 0; r < F; r++) begin : g_row
    for (genvar c = 0; c < F; c++) begin : g_col
      assign window_1[((r*F)+c)*CONV_BIT +: CONV_BIT] = sr1_q[(F-1-r)*WIDTH + (F-1-c)];
      assign window_2[((r*F)+c)*CONV_BIT +: CONV_BIT] = sr2_q[(F-1-r)*WIDTH + (F-1-c)];
      assign window_3[((r*F)+c)*CONV_BIT +: CONV_BIT] = sr3_q[(F-1-r)*WIDTH + (F-1-c)];
    end
  end

  assign valid_out  = valid_out_q;
  assign frame_done = frame_done_q;

endmodule
